// File: rtl/inst_mem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: data width,
// the NOP returned whenever a fetch cannot be served, FSM state encoding
// and the byte-lane insert helper used by the program loader.
package inst_mem_responder_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic {
        IMEM_ST_RUN  = 1'b0,
        IMEM_ST_LOAD = 1'b1
    } imem_state_e;

    // Returns word with byte lane 'lane' replaced by 'data' (little-endian lanes).
    function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  data);
        logic [31:0] result;
        result = word;
        result[{lane, 3'b000} +: 8] = data;
        return result;
    endfunction

endpackage

// File: rtl/inst_mem_responder_packer.sv
// imem_byte_packer: assembles the little-endian byte stream into 32-bit
// words. A word is emitted on the 4th byte, or early (zero-padded) on the
// byte flagged last, so an aligned last byte still produces a single word.
module imem_byte_packer
    import inst_mem_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  data_byte,
    input  logic        last,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt_r;
    logic [31:0] pack_r;
    logic [31:0] merged_s;
    logic        emit_s;

    // Merge the incoming byte into its lane and decide whether a word completes.
    always_comb begin
        merged_s = insert_byte(pack_r, cnt_r, data_byte);
        emit_s   = accept && ((cnt_r == 2'd3) || last);
    end

    assign word_valid = emit_s;
    assign word       = merged_s;

    // Byte counter and partial-word register; cleared after every emitted word.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= 2'd0;
            pack_r <= 32'h0000_0000;
        end else if (clear) begin
            cnt_r  <= 2'd0;
            pack_r <= 32'h0000_0000;
        end else if (emit_s) begin
            cnt_r  <= 2'd0;
            pack_r <= 32'h0000_0000;
        end else if (accept) begin
            cnt_r  <= cnt_r + 2'd1;
            pack_r <= merged_s;
        end else begin
            cnt_r  <= cnt_r;
            pack_r <= pack_r;
        end
    end

endmodule

// File: rtl/inst_mem_responder.sv
// inst_mem_responder: instruction memory with zero-latency fetch port and a
// byte-serial program loader. While loading, fetch returns NOP and
// load_busy_o tells the core to hold its PC.
// Optional build macro: IMEM_FAULT_EN adds fetch_fault_o, flagging
// misaligned or out-of-range fetches (which then return NOP).
module inst_mem_responder
    import inst_mem_responder_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_ce_i,
    input  logic [XLEN-1:0]   inst_addr_i,
    output logic [XLEN-1:0]   inst_o,
`ifdef IMEM_FAULT_EN
    output logic              fetch_fault_o,
`endif
    input  logic              ld_start_i,
    input  logic              ld_valid_i,
    input  logic [7:0]        ld_byte_i,
    input  logic              ld_last_i,
    output logic              ld_ready_o,
    output logic              load_busy_o,
    output logic [$clog2(DEPTH):0] ld_count_o,
    output logic              ld_ovf_o
);

    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] mem_r [DEPTH];

    imem_state_e     state_r;
    logic [AW:0]     wptr_r;
    logic            ld_ovf_r;
    logic            ld_ready_r;
    logic            load_busy_r;

    logic            accept_s;
    logic            full_s;
    logic            word_valid_s;
    logic [31:0]     word_s;
    logic            mem_we_s;
    logic [AW-1:0]   rd_idx_s;
    logic            oor_s;
    logic [XLEN-1:0] inst_s;

    // A start pulse has priority: the byte presented in that cycle is dropped.
    assign accept_s = ld_valid_i && ld_ready_r && !ld_start_i;
    assign full_s   = (wptr_r == (AW+1)'(DEPTH));
    assign mem_we_s = word_valid_s && !full_s;

    imem_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (ld_start_i),
        .accept     (accept_s),
        .data_byte  (ld_byte_i),
        .last       (ld_last_i),
        .word_valid (word_valid_s),
        .word       (word_s)
    );

    // Loader FSM: tracks RUN/LOAD, write pointer (== words written) and overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IMEM_ST_RUN;
            wptr_r      <= '0;
            ld_ovf_r    <= 1'b0;
            ld_ready_r  <= 1'b0;
            load_busy_r <= 1'b0;
        end else begin
            case (state_r)
                IMEM_ST_RUN: begin
                    if (ld_start_i) begin
                        state_r     <= IMEM_ST_LOAD;
                        wptr_r      <= '0;
                        ld_ovf_r    <= 1'b0;
                        ld_ready_r  <= 1'b1;
                        load_busy_r <= 1'b1;
                    end else begin
                        state_r     <= IMEM_ST_RUN;
                    end
                end
                IMEM_ST_LOAD: begin
                    if (ld_start_i) begin
                        wptr_r   <= '0;
                        ld_ovf_r <= 1'b0;
                    end else if (accept_s) begin
                        if (full_s) begin
                            ld_ovf_r <= 1'b1;
                        end else if (word_valid_s) begin
                            wptr_r <= wptr_r + (AW+1)'(1);
                        end else begin
                            wptr_r <= wptr_r;
                        end
                        if (ld_last_i) begin
                            state_r     <= IMEM_ST_RUN;
                            ld_ready_r  <= 1'b0;
                            load_busy_r <= 1'b0;
                        end else begin
                            state_r     <= IMEM_ST_LOAD;
                        end
                    end else begin
                        state_r <= IMEM_ST_LOAD;
                    end
                end
                default: begin
                    state_r     <= IMEM_ST_RUN;
                    ld_ready_r  <= 1'b0;
                    load_busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Program array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[wptr_r[AW-1:0]] <= word_s;
        end else begin
            mem_r[wptr_r[AW-1:0]] <= mem_r[wptr_r[AW-1:0]];
        end
    end

    assign rd_idx_s = inst_addr_i[AW+1:2];
    assign oor_s    = |inst_addr_i[XLEN-1:AW+2];

`ifdef IMEM_FAULT_EN
    logic fault_s;

    // Fetch mux: serve only aligned in-range fetches in RUN, otherwise NOP.
    always_comb begin
        inst_s  = NOP_INST;
        fault_s = 1'b0;
        if (inst_ce_i && (state_r == IMEM_ST_RUN)) begin
            if (oor_s || (inst_addr_i[1:0] != 2'b00)) begin
                fault_s = 1'b1;
            end else begin
                inst_s = mem_r[rd_idx_s];
            end
        end else begin
            inst_s = NOP_INST;
        end
    end

    assign fetch_fault_o = fault_s;
`else
    // Low address bits do not take part in indexing in this build.
    logic unused_addr_lsb_s;
    assign unused_addr_lsb_s = ^inst_addr_i[1:0];

    // Fetch mux: serve in-range fetches in RUN, otherwise NOP.
    always_comb begin
        inst_s = NOP_INST;
        if (inst_ce_i && (state_r == IMEM_ST_RUN) && !oor_s) begin
            inst_s = mem_r[rd_idx_s];
        end else begin
            inst_s = NOP_INST;
        end
    end
`endif

    assign inst_o      = inst_s;
    assign ld_ready_o  = ld_ready_r;
    assign load_busy_o = load_busy_r;
    assign ld_count_o  = wptr_r;
    assign ld_ovf_o    = ld_ovf_r;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Self-checking bench for inst_mem_responder (small DEPTH so overflow is reachable).
module tb_inst_mem_responder;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_ce;
    logic [31:0] inst_addr;
    logic [31:0] inst;
    logic        fetch_fault;
    logic        ld_start, ld_valid, ld_last;
    logic [7:0]  ld_byte;
    logic        ld_ready, load_busy, ld_ovf;
    logic [AW:0] ld_count;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    logic [31:0] ref_mem   [DEPTH];
    bit          ref_valid [DEPTH];
    int          exp_count;
    bit          exp_ovf;
    logic [7:0]  ld_q [$];

    always #5 clk = ~clk;

    inst_mem_responder #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_ce_i   (inst_ce),
        .inst_addr_i (inst_addr),
        .inst_o      (inst),
`ifdef IMEM_FAULT_EN
        .fetch_fault_o (fetch_fault),
`endif
        .ld_start_i  (ld_start),
        .ld_valid_i  (ld_valid),
        .ld_byte_i   (ld_byte),
        .ld_last_i   (ld_last),
        .ld_ready_o  (ld_ready),
        .load_busy_o (load_busy),
        .ld_count_o  (ld_count),
        .ld_ovf_o    (ld_ovf)
    );

`ifndef IMEM_FAULT_EN
    assign fetch_fault = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Words of a byte stream: complete loads pad the tail, aborted loads keep whole words only.
    task automatic model_commit(input bit completed);
        int n, words;
        logic [31:0] val;
        n = ld_q.size();
        words = completed ? (n + 3) / 4 : n / 4;
        for (int w = 0; w < words && w < DEPTH; w++) begin
            val = 32'h0;
            for (int b = 0; b < 4; b++)
                if (4 * w + b < n) val = val | (32'(ld_q[4 * w + b]) << (8 * b));
            ref_mem[w]   = val;
            ref_valid[w] = 1'b1;
        end
        exp_count = (words < DEPTH) ? words : DEPTH;
        exp_ovf   = (n > 4 * DEPTH);
    endtask

    function automatic void model_read(input logic ce, input logic [31:0] addr,
                                       output logic [31:0] exp_inst, output logic exp_flt,
                                       output bit known);
        int unsigned a, idx;
        bit oor;
        a = addr;
        oor = (a >= 4 * DEPTH);
        idx = (a / 4) % DEPTH;
        known = 1'b1;
        exp_flt = 1'b0;
        exp_inst = NOP;
        if (ce) begin
`ifdef IMEM_FAULT_EN
            if (oor || (a % 4 != 0)) exp_flt = 1'b1;
            else if (!ref_valid[idx]) known = 1'b0;
            else exp_inst = ref_mem[idx];
`else
            if (!oor) begin
                if (!ref_valid[idx]) known = 1'b0;
                else exp_inst = ref_mem[idx];
            end
`endif
        end
    endfunction

    task automatic rd(input logic ce, input logic [31:0] addr);
        logic [31:0] e;
        logic f;
        bit known;
        model_read(ce, addr, e, f, known);
        inst_ce = ce;
        inst_addr = addr;
        #1;
        if (known) begin
            chk("read_inst", inst, e);
`ifdef IMEM_FAULT_EN
            chk("read_fault", 32'(fetch_fault), 32'(f));
`endif
        end
        tick();
    endtask

    task automatic busy_chk();
        inst_ce = 1'b1;
        inst_addr = 32'($urandom_range(0, 4 * DEPTH + 7));
        #1;
        chk("load_busy", 32'(load_busy), 32'd1);
        chk("load_ready", 32'(ld_ready), 32'd1);
        chk("load_nop", inst, NOP);
        chk("load_fault", 32'(fetch_fault), 32'd0);
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        ld_valid = 1'($urandom_range(0, 1));
        ld_byte  = 8'($urandom);
        ld_last  = 1'b0;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b0;
        chk("start_busy", 32'(load_busy), 32'd1);
        chk("start_count", 32'(ld_count), 32'd0);
        chk("start_ovf", 32'(ld_ovf), 32'd0);
    endtask

    task automatic stream(input bit with_last, input int max_gap);
        int g;
        for (int i = 0; i < ld_q.size(); i++) begin
            g = $urandom_range(0, max_gap);
            repeat (g) begin
                ld_valid = 1'b0;
                busy_chk();
                tick();
            end
            ld_valid = 1'b1;
            ld_byte  = ld_q[i];
            ld_last  = with_last && (i == ld_q.size() - 1);
            busy_chk();
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic post_chk();
        chk("done_busy", 32'(load_busy), 32'd0);
        chk("done_ready", 32'(ld_ready), 32'd0);
        chk("done_count", 32'(ld_count), 32'(exp_count));
        chk("done_ovf", 32'(ld_ovf), 32'(exp_ovf));
    endtask

    task automatic full_load(input int max_gap);
        start_load();
        stream(1'b1, max_gap);
        model_commit(1'b1);
        post_chk();
    endtask

    typedef struct {
        logic        ce;
        logic [31:0] addr;
        logic [31:0] exp_inst;
        logic        exp_fault;
    } vec_t;

    vec_t vecs [7];

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_valid[i] = 1'b0;
        rst = 1'b1; inst_ce = 1'b0; inst_addr = 32'h0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_byte = 8'h00;
        tick(); tick();
        rst = 1'b0;

        // reset state
        chk("rst_ready", 32'(ld_ready), 32'd0);
        chk("rst_busy", 32'(load_busy), 32'd0);
        chk("rst_count", 32'(ld_count), 32'd0);
        chk("rst_ovf", 32'(ld_ovf), 32'd0);
        chk("rst_ce0_nop", inst, NOP);

        // two-word program
        ld_q = {8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA1, 8'h00};
        full_load(2);
        chk("prog_count2", 32'(ld_count), 32'd2);

        vecs[0] = '{1'b1, 32'h0000_0000, 32'h0050_0093, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0004, 32'h00A1_0113, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0004, NOP,           1'b0};
`ifdef IMEM_FAULT_EN
        vecs[3] = '{1'b1, 32'h0000_0001, NOP,           1'b1};
        vecs[4] = '{1'b1, 32'h0000_0006, NOP,           1'b1};
`else
        vecs[3] = '{1'b1, 32'h0000_0001, 32'h0050_0093, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_0006, 32'h00A1_0113, 1'b0};
`endif
        vecs[5] = '{1'b1, 32'(4 * DEPTH), NOP,          1'b1};
        vecs[6] = '{1'b1, 32'h8000_0000, NOP,           1'b1};
        for (int i = 0; i < 7; i++) begin
            inst_ce = vecs[i].ce;
            inst_addr = vecs[i].addr;
            #1;
            chk($sformatf("vec%0d_inst", i), inst, vecs[i].exp_inst);
`ifdef IMEM_FAULT_EN
            chk($sformatf("vec%0d_fault", i), 32'(fetch_fault), 32'(vecs[i].exp_fault));
`endif
            tick();
        end

        // short image, zero padded
        ld_q = {8'h37, 8'h12};
        full_load(1);
        chk("pad_count1", 32'(ld_count), 32'd1);
        rd(1'b1, 32'h0);
        rd(1'b1, 32'h4);

        // aligned last byte writes exactly one word
        ld_q = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
        full_load(0);
        chk("aligned_count1", 32'(ld_count), 32'd1);
        rd(1'b1, 32'h0);
        rd(1'b1, 32'h4);

        // reset in the middle of a load
        ld_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        start_load();
        stream(1'b0, 1);
        model_commit(1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(load_busy), 32'd0);
        chk("midrst_ready", 32'(ld_ready), 32'd0);
        chk("midrst_count", 32'(ld_count), 32'd0);
        rd(1'b0, 32'h0);
        rd(1'b1, 32'h0);
        rd(1'b1, 32'h4);

        // restart while loading; same-cycle byte is dropped
        ld_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        start_load();
        stream(1'b0, 0);
        model_commit(1'b0);
        ld_start = 1'b1; ld_valid = 1'b1; ld_byte = 8'hFF; ld_last = 1'b1;
        tick();
        ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        chk("restart_busy", 32'(load_busy), 32'd1);
        chk("restart_count", 32'(ld_count), 32'd0);
        ld_q = {8'hAA, 8'hBB};
        stream(1'b1, 0);
        model_commit(1'b1);
        post_chk();
        rd(1'b1, 32'h0);

        // overflow: more bytes than the array holds
        ld_q.delete();
        for (int i = 0; i < 4 * DEPTH + 8; i++) ld_q.push_back(8'($urandom));
        full_load(0);
        chk("ovf_flag", 32'(ld_ovf), 32'd1);
        for (int i = 0; i < DEPTH; i++) rd(1'b1, 32'(4 * i));
        chk("ovf_sticky", 32'(ld_ovf), 32'd1);
        ld_q = {8'h5A};
        full_load(0);

        // random loads and fetches
        for (int r = 0; r < 4; r++) begin
            int len;
            len = $urandom_range(1, 4 * DEPTH + 12);
            ld_q.delete();
            for (int i = 0; i < len; i++) ld_q.push_back(8'($urandom));
            full_load(2);
            for (int k = 0; k < 30; k++)
                rd(1'($urandom_range(0, 3) != 0), 32'($urandom_range(0, 4 * DEPTH + 8)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
